// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for uart_tx_arbiter: per-requester valid,
// byte, frame config and the one-hot accept pulse.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [7*NUM_REQ-1:0] req_cfg_i;
  logic [NUM_REQ-1:0]   req_ready_o;

  modport master (
    output req_valid_i,
    output req_data_i,
    output req_cfg_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  req_cfg_i,
    output req_ready_o
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters,
// with frame hold, inter-frame gap and a watchdog that resets a hung transmitter.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                       tx_clk_i,
  input  logic                       rst_n_i,
  uart_tx_arbiter_if.slave           req_if,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       frame_done_o,
  output logic                       timeout_o,
  output logic                       cfg_err_o,
  output logic                       uart_start_o,
  output logic [7:0]                 uart_data_o,
  output logic [3:0]                 uart_length_o,
  output logic                       uart_parity_type_o,
  output logic                       uart_parity_en_o,
  output logic                       uart_stop2_o,
  output logic                       uart_rst_o,
  input  logic                       uart_done_i
);

  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam int unsigned WDW      = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GPW      = $clog2(GAP_CYCLES + 2);
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  typedef struct packed {
    logic [3:0] length;
    logic       parity_type;
    logic       parity_en;
    logic       stop2;
  } cfg_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [WDW-1:0]     wdog_q;
  logic [GPW-1:0]     gap_q;
  cfg_t               hold_cfg_q;

  logic               sel_found;
  logic [IDW-1:0]     sel_idx;
  int unsigned        cand;
  logic [7:0]         sel_data;
  cfg_t               sel_cfg;
  logic               sel_len_ok;
  logic [NUM_REQ-1:0] ready_c;
  logic               frame_end;

  // First valid requester strictly after the last grant, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_found && req_if.req_valid_i[IDW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    sel_data   = req_if.req_data_i[32'(sel_idx)*8 +: 8];
    sel_cfg    = req_if.req_cfg_i[32'(sel_idx)*7 +: 7];
    sel_len_ok = (sel_cfg.length >= 4'd5) && (sel_cfg.length <= 4'd8);
    ready_c    = '0;
    if (rst_n_i && (state_q == IDLE) && sel_found) ready_c[sel_idx] = 1'b1;
  end

  assign req_if.req_ready_o = ready_c;

  // Done takes precedence over a watchdog expiry in the same cycle.
  assign frame_end = uart_done_i || (wdog_q == WDW'(TIMEOUT_CYCLES - 1));

  assign uart_length_o      = hold_cfg_q.length;
  assign uart_parity_type_o = hold_cfg_q.parity_type;
  assign uart_parity_en_o   = hold_cfg_q.parity_en;
  assign uart_stop2_o       = hold_cfg_q.stop2;

  always_ff @(posedge tx_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NUM_REQ - 1);
      wdog_q       <= '0;
      gap_q        <= '0;
      hold_cfg_q   <= '0;
      uart_data_o  <= '0;
      grant_id_o   <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      timeout_o    <= 1'b0;
      cfg_err_o    <= 1'b0;
      uart_start_o <= 1'b0;
      uart_rst_o   <= 1'b1;
    end else begin
      frame_done_o <= 1'b0;
      timeout_o    <= 1'b0;
      cfg_err_o    <= 1'b0;
      uart_start_o <= 1'b0;
      uart_rst_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            uart_data_o <= sel_data;
            hold_cfg_q  <= sel_cfg;
            grant_id_o  <= sel_idx;
            ptr_q       <= sel_idx;
            if (sel_len_ok) begin
              state_q      <= START;
              uart_start_o <= 1'b1;
              busy_o       <= 1'b1;
            end else begin
              cfg_err_o <= 1'b1;
            end
          end
        end
        START: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (frame_end) begin
            frame_done_o <= uart_done_i;
            timeout_o    <= !uart_done_i;
            uart_rst_o   <= !uart_done_i;
            gap_q        <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              state_q <= GAP;
            end
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        GAP: begin
          if (gap_q == GPW'(GAP_LAST)) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end else begin
            gap_q <= gap_q + GPW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler sharing one uart_tx transmitter among NUM_REQ requesters.
- Accepts one byte plus frame configuration per requester through a valid/ready handshake and drives the transmitter's start, data and config inputs.
- Holds data and config stable for the whole frame, waits for done, then enforces an inter-frame idle gap.
- Recovers a hung frame with a watchdog that resets the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles inserted after each frame before the next grant (0 allowed).
- TIMEOUT_CYCLES, 32, maximum cycles from start pulse to uart_done_i before abort (≥16).

Ports:
- tx_clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- req_valid_i  in  NUM_REQ  per-requester request.
- req_data_i  in  8*NUM_REQ  byte for requester k at [8k+7:8k].
- req_cfg_i  in  7*NUM_REQ  requester k at [7k+6:7k]: {length[3:0], parity_type, parity_en, stop2}.
- req_ready_o  out  NUM_REQ  one-hot, one-cycle accept pulse.
- busy_o  out  1  frame in flight (START, WAIT or GAP).
- grant_id_o  out  $clog2(NUM_REQ)  index of current/last granted requester.
- frame_done_o  out  1  one-cycle pulse on successful completion.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- cfg_err_o  out  1  one-cycle pulse when an accepted request has length outside 5..8.
- uart_start_o  out  1  to tx_start_i.
- uart_data_o  out  8  to tx_data_i.
- uart_length_o  out  4  to length_i.
- uart_parity_type_o  out  1  to parity_type_i.
- uart_parity_en_o  out  1  to parity_en_i.
- uart_stop2_o  out  1  to stop2_i.
- uart_rst_o  out  1  to rst_i (synchronous, active-high).
- uart_done_i  in  1  from tx_done_o.

Behaviour:
- Reset (rst_n_i low, async):
  - State IDLE; all pulses and req_ready_o are 0; grant_id_o = 0; hold registers are 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - uart_rst_o = 1, and stays 1 for the first clock after deassertion.
- Outputs: all outputs are registered except req_ready_o. uart_* data/config come from hold registers and do not change between accept and the next accept.
- States:
  - IDLE:
    - If any req_valid_i, select the first set bit searching upward from pointer+1, with wrap-around.
    - Same cycle: req_ready_o[w] = 1, latch data and cfg into hold registers, grant_id_o <= w, pointer <= w.
    - If the latched length is in 5..8, go to START. Otherwise pulse cfg_err_o next cycle, do not transmit, and stay IDLE.
    - If no request, stay IDLE.
  - START: uart_start_o = 1 for exactly this cycle; clear the watchdog counter; go to WAIT.
  - WAIT:
    - uart_start_o = 0; the watchdog counts each cycle.
    - On uart_done_i = 1: pulse frame_done_o, then go to GAP (or IDLE if GAP_CYCLES = 0).
    - When the counter reaches TIMEOUT_CYCLES without done: pulse timeout_o and uart_rst_o for one cycle, then go to GAP/IDLE as above.
    - If done and timeout occur in the same cycle, done wins: no timeout, no uart_rst_o.
  - GAP: count GAP_CYCLES cycles, then IDLE. Requests are not accepted during GAP.
- Request handling:
  - uart_done_i outside WAIT is ignored.
  - req_valid_i deasserted before grant is simply not served.
  - A requester whose valid stays high is re-served only after all other active requesters (fairness).
- Latency: accept at cycle 0 → uart_start_o at cycle 1 → earliest next accept at cycle (done + 1 + GAP_CYCLES).
- busy_o = 1 in START, WAIT and GAP.
- Mid-frame reset: outputs return to their reset values immediately; uart_rst_o holds the transmitter in reset.

Test Plan:
- Single request: req_valid_i = 4'b0001, data 8'hA5, cfg length 8 with parity even, 1 stop → req_ready_o[0] pulses, uart_start_o 1 cycle later, uart_data_o = 8'hA5 held until frame_done_o, then 2 idle cycles.
- Contention: req_valid_i = 4'b1111 held → grant order 0, 1, 2, 3, 0; each req_ready_o pulses once per round.
- Fairness after grant 2: only bits 1 and 3 valid → next grant is 3, then 1.
- Bad config: length 4'd9 on requester 2 → req_ready_o[2] pulse, cfg_err_o pulse, no uart_start_o, pointer advances to 2.
- Watchdog: uart_done_i stuck 0 → at 32 cycles after start, timeout_o and uart_rst_o pulse together, busy_o clears after the gap. Done arriving in the same cycle as timeout → frame_done_o only.
- Async reset asserted in WAIT → all outputs go to reset values without a clock edge; uart_rst_o = 1 until 1 clock after release; requester 0 is granted first afterwards.
